// File: rtl/dmem_port_scheduler.sv
// Round-robin scheduler that serialises NUM_PORTS requesters onto one single-port data memory.
// Optional performance counters are enabled by defining DMEM_SCHED_PERF_CNT_EN.
module dmem_port_scheduler #(
    parameter int NUM_PORTS       = 2,
    parameter int ADDR_SIZE       = 32,
    parameter int WRITE_DATA_SIZE = 32,
    parameter int READ_DATA_SIZE  = 512,
    parameter int READ_LATENCY    = 2
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [NUM_PORTS-1:0]                 port_read_en,
    input  logic [NUM_PORTS*ADDR_SIZE-1:0]       port_read_addr,
    input  logic [NUM_PORTS-1:0]                 port_write_en,
    input  logic [NUM_PORTS*ADDR_SIZE-1:0]       port_write_addr,
    input  logic [NUM_PORTS*WRITE_DATA_SIZE-1:0] port_write_data,
    output logic [NUM_PORTS-1:0]                 port_read_valid,
    output logic [NUM_PORTS-1:0]                 port_write_done,
    output logic [READ_DATA_SIZE-1:0]            port_read_data,
    output logic                                 dmem_en,
    output logic                                 dmem_we,
    output logic [ADDR_SIZE-1:0]                 dmem_addr,
    output logic [WRITE_DATA_SIZE-1:0]           dmem_wdata,
`ifdef DMEM_SCHED_PERF_CNT_EN
    input  logic                                 perf_clr,
    output logic [31:0]                          perf_reads,
    output logic [31:0]                          perf_writes,
    output logic [31:0]                          perf_stall,
`endif
    input  logic [READ_DATA_SIZE-1:0]            dmem_rdata
);

    localparam int PW = $clog2(NUM_PORTS);
    localparam int CW = $clog2(READ_LATENCY + 1);

    typedef enum logic [2:0] {IDLE, ISSUE_R, ISSUE_W, WAIT_R, DONE_R} state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   gnt_q, gnt_d;
    logic [PW-1:0]   rr_q, rr_d;
    logic [CW-1:0]   lat_q, lat_d;
    logic            capture;

    logic [NUM_PORTS-1:0] req;
    logic                 win_found;
    logic [PW-1:0]        win_idx;
    logic [PW-1:0]        cand;
    logic [PW-1:0]        gnt_next;

    // First requesting port at or after the rr pointer, wrapping modulo NUM_PORTS.
    always_comb begin
        req       = port_read_en | port_write_en;
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            cand = PW'((int'(rr_q) + i) % NUM_PORTS);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
        gnt_next = (int'(gnt_q) == NUM_PORTS - 1) ? '0 : gnt_q + 1'b1;
    end

    // NOTE: every output of this block gets a default before the case, so no latch is inferred.
    always_comb begin
        state_d         = state_q;
        gnt_d           = gnt_q;
        rr_d            = rr_q;
        lat_d           = lat_q;
        capture         = 1'b0;
        dmem_en         = 1'b0;
        dmem_we         = 1'b0;
        dmem_addr       = '0;
        dmem_wdata      = '0;
        port_read_valid = '0;
        port_write_done = '0;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    gnt_d   = win_idx;
                    state_d = port_write_en[win_idx] ? ISSUE_W : ISSUE_R;
                end
            end
            ISSUE_W: begin
                dmem_en                = 1'b1;
                dmem_we                = 1'b1;
                dmem_addr              = port_write_addr[int'(gnt_q)*ADDR_SIZE +: ADDR_SIZE];
                dmem_wdata             = port_write_data[int'(gnt_q)*WRITE_DATA_SIZE +: WRITE_DATA_SIZE];
                port_write_done[gnt_q] = 1'b1;
                rr_d                   = gnt_next;
                state_d                = IDLE;
            end
            ISSUE_R: begin
                dmem_en   = 1'b1;
                dmem_addr = port_read_addr[int'(gnt_q)*ADDR_SIZE +: ADDR_SIZE];
                lat_d     = CW'(READ_LATENCY - 1);
                if (READ_LATENCY == 1) begin
                    capture = 1'b1;
                    state_d = DONE_R;
                end else begin
                    state_d = WAIT_R;
                end
            end
            WAIT_R: begin
                if (lat_q <= CW'(1)) begin
                    capture = 1'b1;
                    lat_d   = '0;
                    state_d = DONE_R;
                end else begin
                    lat_d = lat_q - 1'b1;
                end
            end
            DONE_R: begin
                port_read_valid[gnt_q] = 1'b1;
                rr_d                   = gnt_next;
                state_d                = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together on the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            gnt_q          <= '0;
            rr_q           <= '0;
            lat_q          <= '0;
            port_read_data <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            rr_q    <= rr_d;
            lat_q   <= lat_d;
            if (capture) port_read_data <= dmem_rdata;
        end
    end

`ifdef DMEM_SCHED_PERF_CNT_EN
    logic stall;

    // A requester stalls whenever it is not the port currently holding the memory.
    always_comb begin
        stall = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (req[i] && !(state_q != IDLE && int'(gnt_q) == i)) stall = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_reads  <= '0;
            perf_writes <= '0;
            perf_stall  <= '0;
        end else if (perf_clr) begin
            perf_reads  <= '0;
            perf_writes <= '0;
            perf_stall  <= '0;
        end else begin
            if (state_q == DONE_R && perf_reads != '1)  perf_reads  <= perf_reads + 1'b1;
            if (state_q == ISSUE_W && perf_writes != '1) perf_writes <= perf_writes + 1'b1;
            if (stall && perf_stall != '1)               perf_stall  <= perf_stall + 1'b1;
        end
    end
`endif

endmodule
